// File: rtl/adc_cdac_code_sequencer.sv
// rtl/adc_cdac_code_sequencer.sv - registered binary-to-thermometer CDAC decoder with handshake and sweep modes
//
// Purpose:
//   Takes a DAC code (row | column | binary-cap fields) either from a valid/ready
//   input or from an internal sweep counter. It registers the code (stage 1),
//   then decodes it into active-low thermometer enables for the row/column
//   capacitor array (stage 2).
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   mode[1:0]      00 normal, 01 continuous ramp, 10 single sweep, 11 hold
//   in_valid       data_in is valid
//   in_ready       data_in is accepted this cycle (normal mode only)
//   data_in[DW]    {row, column, bincap} code
//   code_out[DW]   code currently presented on the DAC enables
//   out_valid      one-cycle pulse when the DAC enables update
//   sweep_done     single sweep has presented the maximum code (sticky)
//   row_n_out      active-low row enables
//   rowon_n_out    active-low row-on enables
//   col_n_out      active-low column enables
//   bincap_n_out   active-low binary-weighted caps
//   c0p_n_out      constant 1
//   c0n_n_out      constant 0

module adc_cdac_code_sequencer #(
    parameter  int ROW_BITS = 4,
    parameter  int COL_BITS = 5,
    parameter  int BIN_BITS = 3,
    parameter  int STEP_DIV = 4,
    localparam int DW       = ROW_BITS + COL_BITS + BIN_BITS,
    localparam int NROW     = 2 ** ROW_BITS,
    localparam int NCOL     = 2 ** COL_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       data_in,
    output logic [DW-1:0]       code_out,
    output logic                out_valid,
    output logic                sweep_done,
    output logic [NROW-1:0]     row_n_out,
    output logic [NROW-1:0]     rowon_n_out,
    output logic [NCOL-1:0]     col_n_out,
    output logic [BIN_BITS-1:0] bincap_n_out,
    output logic                c0p_n_out,
    output logic                c0n_n_out
);

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_RAMP   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // A 1-bit divider still works for STEP_DIV=1: it sits at 0 and wraps every clock.
    localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [DW-1:0]    CODE_MAX = '1;

    // Decode of code 0: only row 0 and column 0 enabled, no row-on, no binary caps.
    localparam logic [NROW-1:0]     RST_ROW_N   = ~(NROW'(1));
    localparam logic [NROW-1:0]     RST_ROWON_N = '1;
    localparam logic [NCOL-1:0]     RST_COL_N   = ~(NCOL'(1));
    localparam logic [BIN_BITS-1:0] RST_BIN_N   = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          mode_q, mode_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic                swept_q, swept_d;        // max code already issued in this single sweep
    logic [DW-1:0]       code_q, code_d;          // stage 1
    logic                s1_valid_q, s1_valid_d;  // stage 1 holds a code not yet presented
    logic [DW-1:0]       code_out_q, code_out_d;  // stage 2
    logic                out_valid_q, out_valid_d;
    logic                sweep_done_q, sweep_done_d;
    logic [NROW-1:0]     row_n_q, row_n_d;
    logic [NROW-1:0]     rowon_n_q, rowon_n_d;
    logic [NCOL-1:0]     col_n_q, col_n_d;
    logic [BIN_BITS-1:0] bin_n_q, bin_n_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic sweep_mode;
    logic sweep_entry;
    logic div_wrap;
    logic issue;
    logic accept;
    logic hold;
    logic load_s2;

    assign hold        = (mode == MODE_HOLD);
    assign sweep_mode  = (mode == MODE_RAMP) || (mode == MODE_SWEEP);
    // Any transition into 01/10, including 01<->10, restarts the sweep from code 0.
    assign sweep_entry = sweep_mode && (mode != mode_q);
    assign div_wrap    = (div_q == DIV_LAST);
    // A single sweep issues the max code once and then stops stepping.
    assign issue       = sweep_mode && !sweep_entry && div_wrap
                         && !((mode == MODE_SWEEP) && swept_q);
    // The mode sampled this cycle decides acceptance, so in_ready is combinational on mode.
    assign in_ready    = !rst && (mode == MODE_NORMAL);
    assign accept      = in_valid && in_ready;
    assign load_s2     = s1_valid_q && !hold;

    // ------------------------------------------------------------------
    // Thermometer decode of the stage-1 code
    // ------------------------------------------------------------------
    logic [ROW_BITS-1:0] row_code;
    logic [COL_BITS-1:0] col_code;
    logic [NROW-1:0]     dec_row;
    logic [NROW-1:0]     dec_rowon;
    logic [NCOL-1:0]     dec_col;
    logic [BIN_BITS-1:0] dec_bin;

    assign row_code = code_q[DW-1 -: ROW_BITS];
    assign col_code = code_q[BIN_BITS +: COL_BITS];

    always_comb begin
        dec_row = '0;
        for (int j = 0; j < NROW; j++) begin
            dec_row[j] = (int'(row_code) >= j);
        end
        // Rows strictly below the active row are fully on.
        dec_rowon = dec_row >> 1;
        // Serpentine fill: odd rows fill columns from the top end so that
        // stepping the column code moves the active cap continuously.
        dec_col = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (row_code[0]) begin
                dec_col[i] = (int'(col_code) >= (NCOL - 1 - i));
            end else begin
                dec_col[i] = (int'(col_code) >= i);
            end
        end
        dec_bin = code_q[BIN_BITS-1:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mode_d       = mode;
        div_d        = div_q;
        cnt_d        = cnt_q;
        swept_d      = swept_q;
        code_d       = code_q;
        s1_valid_d   = s1_valid_q;
        code_out_d   = code_out_q;
        out_valid_d  = 1'b0;
        sweep_done_d = sweep_done_q;
        row_n_d      = row_n_q;
        rowon_n_d    = rowon_n_q;
        col_n_d      = col_n_q;
        bin_n_d      = bin_n_q;

        // Sweep counter and divider
        if (sweep_entry) begin
            div_d   = '0;
            cnt_d   = '0;
            swept_d = 1'b0;
        end else if (sweep_mode) begin
            div_d = div_wrap ? '0 : div_q + DIV_W'(1);
            if (issue) begin
                if ((mode == MODE_SWEEP) && (cnt_q == CODE_MAX)) begin
                    swept_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
        end
        if (mode != MODE_SWEEP) begin
            swept_d = 1'b0;
        end

        // Stage 1: hold freezes it, otherwise it takes a new code or drains.
        if (!hold) begin
            if (accept) begin
                code_d     = data_in;
                s1_valid_d = 1'b1;
            end else if (issue) begin
                code_d     = cnt_q;
                s1_valid_d = 1'b1;
            end else begin
                s1_valid_d = 1'b0;
            end
        end

        // Stage 2
        if (load_s2) begin
            out_valid_d = 1'b1;
            code_out_d  = code_q;
            row_n_d     = ~dec_row;
            rowon_n_d   = ~dec_rowon;
            col_n_d     = ~dec_col;
            bin_n_d     = ~dec_bin;
        end

        // swept_q guards against a leftover max code from normal mode setting the flag.
        if (mode != MODE_SWEEP) begin
            sweep_done_d = 1'b0;
        end else if (load_s2 && swept_q && (code_q == CODE_MAX)) begin
            sweep_done_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_NORMAL;
            div_q        <= '0;
            cnt_q        <= '0;
            swept_q      <= 1'b0;
            code_q       <= '0;
            s1_valid_q   <= 1'b0;
            code_out_q   <= '0;
            out_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            row_n_q      <= RST_ROW_N;
            rowon_n_q    <= RST_ROWON_N;
            col_n_q      <= RST_COL_N;
            bin_n_q      <= RST_BIN_N;
        end else begin
            mode_q       <= mode_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            swept_q      <= swept_d;
            code_q       <= code_d;
            s1_valid_q   <= s1_valid_d;
            code_out_q   <= code_out_d;
            out_valid_q  <= out_valid_d;
            sweep_done_q <= sweep_done_d;
            row_n_q      <= row_n_d;
            rowon_n_q    <= rowon_n_d;
            col_n_q      <= col_n_d;
            bin_n_q      <= bin_n_d;
        end
    end

    assign code_out     = code_out_q;
    assign out_valid    = out_valid_q;
    assign sweep_done   = sweep_done_q;
    assign row_n_out    = row_n_q;
    assign rowon_n_out  = rowon_n_q;
    assign col_n_out    = col_n_q;
    assign bincap_n_out = bin_n_q;
    assign c0p_n_out    = 1'b1;
    assign c0n_n_out    = 1'b0;

endmodule

// File: tb/tb_adc_cdac_code_sequencer.sv
// tb/tb_adc_cdac_code_sequencer.sv - self-checking bench for adc_cdac_code_sequencer

module tb_adc_cdac_code_sequencer;

    localparam int SD = 4;
    localparam int NCODES = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] data_in;
    logic [11:0] code_out;
    logic        out_valid;
    logic        sweep_done;
    logic [15:0] row_n_out;
    logic [15:0] rowon_n_out;
    logic [31:0] col_n_out;
    logic [2:0]  bincap_n_out;
    logic        c0p_n_out;
    logic        c0n_n_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [11:0] model_out;

    adc_cdac_code_sequencer #(
        .ROW_BITS (4),
        .COL_BITS (5),
        .BIN_BITS (3),
        .STEP_DIV (SD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .code_out     (code_out),
        .out_valid    (out_valid),
        .sweep_done   (sweep_done),
        .row_n_out    (row_n_out),
        .rowon_n_out  (rowon_n_out),
        .col_n_out    (col_n_out),
        .bincap_n_out (bincap_n_out),
        .c0p_n_out    (c0p_n_out),
        .c0n_n_out    (c0n_n_out)
    );

    always #5 clk = ~clk;

    // Reference decode from the thermometer rules using mask arithmetic.
    function automatic logic [66:0] exp_dec(input logic [11:0] c);
        int          r;
        int          cc;
        logic [63:0] rm;
        logic [63:0] cm;
        logic [15:0] rw;
        logic [15:0] ro;
        logic [31:0] cl;
        logic [2:0]  b;
        r  = int'(c[11:8]);
        cc = int'(c[7:3]);
        rm = (64'd1 << (r + 1)) - 64'd1;
        rw = ~rm[15:0];
        ro = ~rm[16:1];
        if ((r % 2) == 0) cm = (64'd1 << (cc + 1)) - 64'd1;
        else              cm = ~((64'd1 << (31 - cc)) - 64'd1);
        cl = ~cm[31:0];
        b  = ~c[2:0];
        return {rw, ro, cl, b};
    endfunction

    function automatic logic [66:0] dut_dec();
        return {row_n_out, rowon_n_out, col_n_out, bincap_n_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; in_valid = 1'b0; data_in = '0;
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (sweep_done !== 1'b0) $display("FAIL reset_sweep_done: got %b want 0", sweep_done); else pass_cnt++;
        total_cnt++; if (code_out !== 12'h000) $display("FAIL reset_code_out: got %h want 000", code_out); else pass_cnt++;
        total_cnt++; if (dut_dec() !== exp_dec(12'h000)) $display("FAIL reset_decode: got %h want %h", dut_dec(), exp_dec(12'h000)); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if ({c0p_n_out, c0n_n_out} !== 2'b10) $display("FAIL c0_consts: got %b want 10", {c0p_n_out, c0n_n_out}); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL normal_in_ready: got %b want 1", in_ready); else pass_cnt++;
        model_out = 12'h000;
    endtask

    task automatic test_fixed_codes();
        logic [11:0] codes [4];
        codes[0] = 12'h000; codes[1] = 12'h1FD; codes[2] = 12'h308; codes[3] = 12'hFFF;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1; data_in = codes[n];
            tick();
            in_valid = 1'b0; data_in = '0;
            tick();
            model_out = codes[n];
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL fixed_out_valid[%0d]: got %b want 1", n, out_valid); else pass_cnt++;
            total_cnt++; if (code_out !== model_out) $display("FAIL fixed_code_out[%0d]: got %h want %h", n, code_out, model_out); else pass_cnt++;
            total_cnt++; if (dut_dec() !== exp_dec(model_out)) $display("FAIL fixed_decode[%0d]: got %h want %h", n, dut_dec(), exp_dec(model_out)); else pass_cnt++;
            tick();
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL fixed_pulse_end[%0d]: got %b want 0", n, out_valid); else pass_cnt++;
            total_cnt++; if (code_out !== model_out) $display("FAIL fixed_hold[%0d]: got %h want %h", n, code_out, model_out); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin in_valid = 1'b1; data_in = 12'(i + 1); end
            else       begin in_valid = 1'b0; data_in = '0; end
            tick();
            if (i >= 1) begin
                if (i <= 8) model_out = 12'(i);
                total_cnt++; if (out_valid !== (i <= 8)) $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, (i <= 8)); else pass_cnt++;
                total_cnt++; if (code_out !== model_out) $display("FAIL b2b_code[%0d]: got %h want %h", i, code_out, model_out); else pass_cnt++;
            end
        end
    endtask

    task automatic test_random_normal();
        logic        pa = 1'b0;
        logic [11:0] pc = '0;
        logic        v;
        logic [11:0] d;
        for (int t = 0; t < 200; t++) begin
            v = (t < 198) ? 1'($urandom_range(0, 1)) : 1'b0;
            d = 12'($urandom);
            in_valid = v; data_in = d;
            tick();
            if (pa) model_out = pc;
            total_cnt++; if (out_valid !== pa) $display("FAIL rand_valid[%0d]: got %b want %b", t, out_valid, pa); else pass_cnt++;
            total_cnt++; if (code_out !== model_out) $display("FAIL rand_code[%0d]: got %h want %h", t, code_out, model_out); else pass_cnt++;
            total_cnt++; if (dut_dec() !== exp_dec(model_out)) $display("FAIL rand_decode[%0d]: got %h want %h", t, dut_dec(), exp_dec(model_out)); else pass_cnt++;
            pa = v; pc = d;
        end
        in_valid = 1'b0;
        tick(); tick();
    endtask

    // Code k appears SD+1 clocks after entry plus SD clocks per step.
    task automatic test_single_sweep();
        int   k = 0;
        int   last;
        logic done = 1'b0;
        logic pulse;
        mode = 2'b10; in_valid = 1'b0;
        tick();
        last = SD + 1 + SD * (NCODES - 1) + 20;
        for (int cyc = 1; cyc <= last; cyc++) begin
            tick();
            pulse = (cyc >= SD + 1) && (((cyc - SD - 1) % SD) == 0) && (k < NCODES);
            if (pulse) begin
                model_out = 12'(k);
                if (k == NCODES - 1) done = 1'b1;
                k++;
            end
            total_cnt++; if (out_valid !== pulse) $display("FAIL sweep_valid[%0d]: got %b want %b", cyc, out_valid, pulse); else pass_cnt++;
            total_cnt++; if (sweep_done !== done) $display("FAIL sweep_done[%0d]: got %b want %b", cyc, sweep_done, done); else pass_cnt++;
            if (pulse) begin
                total_cnt++; if (code_out !== model_out) $display("FAIL sweep_code[%0d]: got %h want %h", cyc, code_out, model_out); else pass_cnt++;
                total_cnt++; if (dut_dec() !== exp_dec(model_out)) $display("FAIL sweep_decode[%0d]: got %h want %h", cyc, dut_dec(), exp_dec(model_out)); else pass_cnt++;
            end
        end
        total_cnt++; if (code_out !== 12'hFFF) $display("FAIL sweep_final_code: got %h want fff", code_out); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        mode = 2'b00;
        tick();
        total_cnt++; if (sweep_done !== 1'b0) $display("FAIL done_clear_on_exit: got %b want 0", sweep_done); else pass_cnt++;
        mode = 2'b10;
        for (int i = 0; i < 50 + $urandom_range(0, 7); i++) tick();
        total_cnt++; if (code_out === 12'h000) $display("FAIL midsweep_progress: got %h want nonzero", code_out); else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++; if (code_out !== 12'h000) $display("FAIL rst_mid_code: got %h want 000", code_out); else pass_cnt++;
        total_cnt++; if (dut_dec() !== exp_dec(12'h000)) $display("FAIL rst_mid_decode: got %h want %h", dut_dec(), exp_dec(12'h000)); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (sweep_done !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", sweep_done); else pass_cnt++;
        rst = 1'b0; mode = 2'b00;
        tick();
        model_out = 12'h000;
    endtask

    task automatic test_ramp_wrap();
        int   k = 0;
        int   last;
        logic pulse;
        mode = 2'b01; in_valid = 1'b0;
        tick();
        last = SD + 1 + SD * NCODES;
        for (int cyc = 1; cyc <= last; cyc++) begin
            tick();
            pulse = (cyc >= SD + 1) && (((cyc - SD - 1) % SD) == 0);
            if (pulse) begin
                model_out = 12'(k % NCODES);
                k++;
            end
            total_cnt++; if (out_valid !== pulse) $display("FAIL ramp_valid[%0d]: got %b want %b", cyc, out_valid, pulse); else pass_cnt++;
            total_cnt++; if (sweep_done !== 1'b0) $display("FAIL ramp_done[%0d]: got %b want 0", cyc, sweep_done); else pass_cnt++;
            if (pulse) begin
                total_cnt++; if (code_out !== model_out) $display("FAIL ramp_code[%0d]: got %h want %h", cyc, code_out, model_out); else pass_cnt++;
            end
        end
        total_cnt++; if (code_out !== 12'h000) $display("FAIL ramp_wrap_code: got %h want 000", code_out); else pass_cnt++;
    endtask

    task automatic test_hold();
        mode = 2'b11; in_valid = 1'b1; data_in = 12'hABC;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready: got %b want 0", in_ready); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_valid[%0d]: got %b want 0", i, out_valid); else pass_cnt++;
            total_cnt++; if (code_out !== model_out) $display("FAIL hold_code[%0d]: got %h want %h", i, code_out, model_out); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); else pass_cnt++;
        end
        total_cnt++; if (dut_dec() !== exp_dec(model_out)) $display("FAIL hold_decode: got %h want %h", dut_dec(), exp_dec(model_out)); else pass_cnt++;
        mode = 2'b00; in_valid = 1'b0;
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_no_accept_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (code_out !== model_out) $display("FAIL hold_no_accept_code: got %h want %h", code_out, model_out); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fixed_codes();
        test_back_to_back();
        test_random_normal();
        test_single_sweep();
        test_reset_mid_sweep();
        test_ramp_wrap();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_cdac_code_sequencer.md
Name: adc_cdac_code_sequencer

Overview:
- Registered, parametrised binary-to-thermometer decoder for the row/column capacitor DAC array. It adds a valid/ready input handshake, a two-stage pipeline and built-in code-sweep modes for DAC linearity characterisation.
- Sits between the SAR control logic, or the test/config interface, and the CDAC switch drivers.
- Drives active-low row, rowon, column and binary-cap enables.

Parameters:
- ROW_BITS, 4, row code width; rows = 2**ROW_BITS.
- COL_BITS, 5, column code width; columns = 2**COL_BITS.
- BIN_BITS, 3, binary-weighted LSB cap count.
- STEP_DIV, 4, clock cycles per code step in sweep modes; legal range >=1.
- DW, ROW_BITS+COL_BITS+BIN_BITS, derived input code width; not overridable.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 = normal, 01 = continuous ramp, 10 = single sweep, 11 = hold.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block accepts data_in this cycle.
- data_in  in  DW  code: [DW-1:DW-ROW_BITS] row, next COL_BITS column, [BIN_BITS-1:0] bincap.
- code_out  out  DW  code currently presented on the DAC outputs.
- out_valid  out  1  one-cycle pulse when DAC outputs update.
- sweep_done  out  1  single sweep reached the maximum code; sticky.
- row_n_out  out  2**ROW_BITS  active-low row enables.
- rowon_n_out  out  2**ROW_BITS  active-low row-on enables.
- col_n_out  out  2**COL_BITS  active-low column enables.
- bincap_n_out  out  BIN_BITS  active-low binary caps.
- c0p_n_out  out  1  constant 1.
- c0n_n_out  out  1  constant 0.

Behaviour:
- Reset (rst=1 at an edge):
  - code register and output register go to 0; sweep counter and divider go to 0.
  - out_valid=0, sweep_done=0.
  - row_n_out = all-ones except bit0=0.
  - rowon_n_out = all-ones.
  - col_n_out = all-ones except bit0=0.
  - bincap_n_out = all-ones.
  - This is the decode of code 0. Reset mid-sweep aborts the sweep immediately.
- Decode function, for row code R, column code C and bincap B:
  - row[j] = (R >= j).
  - rowon = row >> 1, with a zero shifted into the MSB.
  - R even: col[i] = (C >= i). R odd: col[i] = (C >= ncol-1-i). This is the serpentine fill.
  - bincap = B.
  - All outputs are the inverse of these values.
- Pipeline:
  - Stage 1 is the code register (next_code).
  - Stage 2 is the decoded output register.
  - Latency from acceptance to output is 2 cycles.
  - code_out is registered alongside stage 2, so it always matches the decoded outputs.
  - out_valid pulses in the same cycle stage 2 loads.
- Normal mode (00):
  - in_ready = 1 whenever rst=0.
  - A code is accepted when in_valid and in_ready are both high.
  - Back-to-back transfers are sustained, one code per cycle.
  - With no in_valid, the outputs hold.
- Continuous ramp (01):
  - in_ready = 0.
  - The divider counts 0..STEP_DIV-1. On wrap, the sweep counter increments and the new code is issued into stage 1.
  - Stepping from 2**DW-1 wraps to 0.
- Single sweep (10):
  - Same as ramp, but the counter stops at 2**DW-1.
  - sweep_done is set in the cycle the max code reaches stage 2. It stays set until reset or until mode leaves 10.
- Hold (11):
  - in_ready = 0; no pipeline movement; outputs frozen; out_valid = 0.
- Mode change:
  - On entry to 01 or 10 from another mode, the counter and divider clear to 0. The first sweep code (0) is issued on the next divider wrap.
  - Any code already in stage 1 still propagates to stage 2.
- Simultaneous events:
  - rst dominates everything.
  - in_valid is ignored while in_ready=0.
  - A mode change and in_valid in the same cycle: the mode sampled in that cycle decides whether the input is accepted.
- STEP_DIV=1 steps one code per clock.

Test Plan:
- Reset, then mode=00, in_valid=1, data_in=0x000 -> after 2 cycles: row_n_out=0xFFFE, rowon_n_out=0xFFFF, col_n_out=0xFFFFFFFE, bincap_n_out=3'b111, out_valid=1, code_out=0x000.
- mode=00, data_in=0x1FD (R=1, C=31, B=5) -> row_n_out=0xFFFC, rowon_n_out=0xFFFE, col_n_out=0x00000000, bincap_n_out=3'b010. Then data_in=0x308 (R=3, C=1, B=0) -> col_n_out=0x3FFFFFFF.
- mode=00, data_in=0xFFF -> row_n_out=0x0000, rowon_n_out=0x8000, col_n_out=0x00000000, bincap_n_out=0.
- mode=00 with in_valid held high for 8 cycles carrying codes 1..8 -> 8 consecutive out_valid pulses; code_out sequence 1..8 at 2-cycle latency.
- mode=10, STEP_DIV=4 -> code_out steps 0..0xFFF every 4 cycles; sweep_done rises when code_out=0xFFF and stays set; pulsing rst mid-sweep returns all outputs to the code-0 pattern next cycle with sweep_done=0.
- mode=01 across the wrap -> code_out goes 0xFFE, 0xFFF, 0x000. Switching to mode=11 freezes code_out, with out_valid=0 and in_ready=0 while in_valid=1.
